csb_master: RTL and testbench

CSB initiator that converts single host register accesses into NVDLA CSB transactions, driving the request channel and collecting read data or write completions. It sits between the HWPE-side control/register path and the NVDLA CSB port, and serves as the stimulus side for CSB responder models in test. One transaction is outstanding at a time; every accepted host request produces exactly one host response pulse.

---
 rtl/csb_pkg.sv | 15 +
 rtl/csb_master_timer.sv | 29 ++
 rtl/csb_master.sv | 157 +++++++++++++++
 tb/tb_csb_master.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csb_pkg.sv
// Shared widths and the state encoding for the CSB initiator.
package csb_pkg;

  localparam int CSB_ADDR_W = 16;
  localparam int CSB_DATA_W = 32;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_REQ        = 3'd1,
    S_WAIT_READ  = 3'd2,
    S_WAIT_WRITE = 3'd3,
    S_RESP       = 3'd4
  } csb_master_state_e;

endpackage

// File: rtl/csb_master_timer.sv
// Response-wait timer for csb_master; only built when CSB_MASTER_TIMEOUT_EN is defined.
`ifdef CSB_MASTER_TIMEOUT_EN
module csb_master_timer #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [15:0] count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable) begin
      count_q <= count_q + 16'd1;
    end
  end

  // Expire on the last counted cycle so the exit lands exactly TIMEOUT_CYCLES after wait entry.
  assign expired = enable && (count_q == 16'(TIMEOUT_CYCLES - 1));

endmodule
`endif

// File: rtl/csb_master.sv
// CSB initiator: one host register access at a time turned into a CSB request plus one response pulse.
// Optional response timeout is compiled in with CSB_MASTER_TIMEOUT_EN.
module csb_master
  import csb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [CSB_ADDR_W-1:0] req_addr_i,
  input  logic [CSB_DATA_W-1:0] req_wdata_i,
  input  logic                  req_write_i,
  input  logic                  req_nposted_i,
  output logic                  rsp_valid_o,
  output logic [CSB_DATA_W-1:0] rsp_rdata_o,
  output logic                  rsp_error_o,
  output logic                  csb_valid_o,
  output logic [CSB_ADDR_W-1:0] csb_addr_o,
  output logic [CSB_DATA_W-1:0] csb_wdat_o,
  output logic                  csb_write_o,
  output logic                  csb_nposted_o,
  input  logic                  csb_ready_i,
  input  logic                  csb_r_valid_i,
  input  logic [CSB_DATA_W-1:0] csb_r_data_i,
  input  logic                  csb_wr_complete_i,
  output logic                  stray_rsp_o,
  output csb_master_state_e     dbg_state_o
);

  // Handshakes: a transfer happens on a rising edge where valid & ready are both high;
  // valid is never withdrawn and its fields never change until that transfer.
  csb_master_state_e     state_q, state_d;
  logic [CSB_ADDR_W-1:0] addr_q;
  logic [CSB_DATA_W-1:0] wdata_q;
  logic [CSB_DATA_W-1:0] rdata_q;
  logic                  write_q;
  logic                  nposted_q;
  logic                  stray_q;
  logic                  stray_set;
  logic                  timed_out;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:       if (req_valid_i) state_d = S_REQ;
      S_REQ: begin
        if (csb_ready_i) begin
          if (!write_q)      state_d = S_WAIT_READ;
          else if (nposted_q) state_d = S_WAIT_WRITE;
          else               state_d = S_RESP;
        end
      end
      S_WAIT_READ:  if (csb_r_valid_i || timed_out) state_d = S_RESP;
      S_WAIT_WRITE: if (csb_wr_complete_i || timed_out) state_d = S_RESP;
      S_RESP:       state_d = S_IDLE;
      default:      state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready_o = 1'b0;
    csb_valid_o = 1'b0;
    rsp_valid_o = 1'b0;
    case (state_q)
      S_IDLE:  req_ready_o = 1'b1;
      S_REQ:   csb_valid_o = 1'b1;
      S_RESP:  rsp_valid_o = 1'b1;
      default: ;
    endcase
  end

  // A response is only expected in the matching wait state; anything else is recorded.
  assign stray_set = (csb_r_valid_i && state_q != S_WAIT_READ) ||
                     (csb_wr_complete_i && state_q != S_WAIT_WRITE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      write_q   <= 1'b0;
      nposted_q <= 1'b0;
      stray_q   <= 1'b0;
    end else begin
      if (state_q == S_IDLE && req_valid_i) begin
        addr_q    <= req_addr_i;
        wdata_q   <= req_wdata_i;
        write_q   <= req_write_i;
        nposted_q <= req_write_i & req_nposted_i;
        rdata_q   <= '0;
      end
      if (state_q == S_WAIT_READ && csb_r_valid_i) begin
        rdata_q <= csb_r_data_i;
      end
      if (stray_set) begin
        stray_q <= 1'b1;
      end
    end
  end

`ifdef CSB_MASTER_TIMEOUT_EN
  logic in_wait;
  logic error_q;
  logic timeout_taken;

  assign in_wait = (state_q == S_WAIT_READ) || (state_q == S_WAIT_WRITE);

  csb_master_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (csb_valid_o && csb_ready_i),
    .enable (in_wait),
    .expired(timed_out)
  );

  // A response arriving on the expiry cycle still wins over the timeout.
  assign timeout_taken = timed_out &&
                         ((state_q == S_WAIT_READ && !csb_r_valid_i) ||
                          (state_q == S_WAIT_WRITE && !csb_wr_complete_i));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      error_q <= 1'b0;
    end else if (state_q == S_IDLE) begin
      error_q <= 1'b0;
    end else if (timeout_taken) begin
      error_q <= 1'b1;
    end
  end

  assign rsp_error_o = rsp_valid_o & error_q;
`else
  assign timed_out   = 1'b0;
  assign rsp_error_o = 1'b0;
`endif

  assign rsp_rdata_o   = rsp_valid_o ? rdata_q : '0;
  assign csb_addr_o    = addr_q;
  assign csb_wdat_o    = wdata_q;
  assign csb_write_o   = write_q;
  assign csb_nposted_o = nposted_q;
  assign stray_rsp_o   = stray_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_csb_master.sv
// Self-checking bench for csb_master: vector table, hand-written corner sequences, response scoreboard.
module tb_csb_master;
  import csb_pkg::*;

  localparam int TO_CYCLES = 8;

  typedef struct {
    logic        write;
    logic        nposted;
    logic [15:0] addr;
    logic [31:0] wdata;
    int          stall;
    int          rsp_delay;
    logic [31:0] rdata;
  } vec_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [15:0]       req_addr = '0;
  logic [31:0]       req_wdata = '0;
  logic              req_write = 1'b0;
  logic              req_nposted = 1'b0;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_error;
  logic              csb_valid;
  logic [15:0]       csb_addr;
  logic [31:0]       csb_wdat;
  logic              csb_write;
  logic              csb_nposted;
  logic              csb_ready = 1'b0;
  logic              csb_r_valid = 1'b0;
  logic [31:0]       csb_r_data = '0;
  logic              csb_wr_complete = 1'b0;
  logic              stray_rsp;
  csb_master_state_e dbg_state;

  int          n_tests = 0;
  int          n_fail = 0;
  int          cyc = 0;
  logic [32:0] exp_q[$];
  vec_t        vecs[11];

  csb_master #(.TIMEOUT_CYCLES(TO_CYCLES)) dut (
    .clk              (clk),
    .rst              (rst),
    .req_valid_i      (req_valid),
    .req_ready_o      (req_ready),
    .req_addr_i       (req_addr),
    .req_wdata_i      (req_wdata),
    .req_write_i      (req_write),
    .req_nposted_i    (req_nposted),
    .rsp_valid_o      (rsp_valid),
    .rsp_rdata_o      (rsp_rdata),
    .rsp_error_o      (rsp_error),
    .csb_valid_o      (csb_valid),
    .csb_addr_o       (csb_addr),
    .csb_wdat_o       (csb_wdat),
    .csb_write_o      (csb_write),
    .csb_nposted_o    (csb_nposted),
    .csb_ready_i      (csb_ready),
    .csb_r_valid_i    (csb_r_valid),
    .csb_r_data_i     (csb_r_data),
    .csb_wr_complete_i(csb_wr_complete),
    .stray_rsp_o      (stray_rsp),
    .dbg_state_o      (dbg_state)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every response pulse pops and compares {error, rdata}
  always @(negedge clk) begin
    if (rsp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", 1, 0);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        check("rsp_data", {rsp_error, rsp_rdata}, e);
      end
    end
  end

  task automatic check_reset_values(input string tag);
    check({tag, "_req_ready"}, req_ready, 1);
    check({tag, "_csb_valid"}, csb_valid, 0);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_rsp_rdata"}, rsp_rdata, 0);
    check({tag, "_rsp_error"}, rsp_error, 0);
    check({tag, "_csb_fields"}, {csb_addr, csb_wdat, csb_write, csb_nposted}, 0);
    check({tag, "_stray"}, stray_rsp, 0);
  endtask

  function automatic vec_t mk(input logic w, input logic np, input logic [15:0] a,
                              input logic [31:0] wd, input int st, input int dl,
                              input logic [31:0] rd);
    vec_t v;
    v.write = w; v.nposted = np; v.addr = a; v.wdata = wd;
    v.stall = st; v.rsp_delay = dl; v.rdata = rd;
    return v;
  endfunction

  task automatic host_drive(input vec_t v);
    req_addr    = v.addr;
    req_wdata   = v.wdata;
    req_write   = v.write;
    req_nposted = v.nposted;
    req_valid   = 1'b1;
  endtask

  task automatic wait_ready(output int acc);
    int n = 0;
    while (req_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("ready_wait_timeout", 0, 1);
    acc = cyc;
  endtask

  // Responder: stalls ready, checks request stability, then optionally answers
  task automatic csb_serve(input vec_t v, input bit respond);
    int n = 0;
    while (csb_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i <= v.stall; i++) begin
      check("csb_valid", csb_valid, 1);
      check("csb_addr", csb_addr, v.addr);
      check("csb_wdat", csb_wdat, v.wdata);
      check("csb_write_np", {csb_write, csb_nposted}, {v.write, v.write & v.nposted});
      if (i == v.stall) csb_ready = 1'b1;
      @(negedge clk);
    end
    csb_ready = 1'b0;
    if (respond && !(v.write && !v.nposted)) begin
      repeat (v.rsp_delay) @(negedge clk);
      if (v.write) begin
        csb_wr_complete = 1'b1;
      end else begin
        csb_r_valid = 1'b1;
        csb_r_data  = v.rdata;
      end
      @(negedge clk);
      csb_r_valid     = 1'b0;
      csb_wr_complete = 1'b0;
      csb_r_data      = '0;
    end
  endtask

  task automatic run_vec(input vec_t v);
    int acc;
    int exp_lat;
    exp_q.push_back({1'b0, v.write ? 32'h0 : v.rdata});
    host_drive(v);
    wait_ready(acc);
    @(negedge clk);
    req_valid = 1'b0;
    check("ready_low_in_req", req_ready, 0);
    csb_serve(v, 1'b1);
    exp_lat = 2 + v.stall + ((v.write && !v.nposted) ? 0 : v.rsp_delay + 1);
    check("rsp_valid", rsp_valid, 1);
    check("rsp_latency", cyc - acc, exp_lat);
    @(negedge clk);
    check("rsp_pulse_end", rsp_valid, 0);
    check("ready_back", req_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v1, v2;
    int acc, w, n;

    vecs[0] = mk(0, 0, 16'h0010, 32'h0,        0, 0, 32'hDEADBEEF);
    vecs[1] = mk(1, 1, 16'h0004, 32'h12345678, 5, 0, 32'h0);
    vecs[2] = mk(1, 0, 16'h0020, 32'hCAFEF00D, 0, 0, 32'h0);
    vecs[3] = mk(0, 0, 16'hFFFF, 32'h0,        2, 3, 32'hA5A55A5A);
    vecs[4] = mk(0, 1, 16'h0000, 32'h0,        0, 1, 32'h0);
    vecs[5] = mk(1, 1, 16'h8000, 32'hFFFFFFFF, 1, 2, 32'h0);
    vecs[6] = mk(1, 0, 16'h1234, 32'h00000001, 3, 0, 32'h0);
    for (int i = 7; i < 11; i++) begin
      vecs[i] = mk(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   16'($urandom_range(0, 65535)), $urandom, $urandom_range(0, 4),
                   $urandom_range(0, 3), $urandom);
    end

    // Reset
    #1;
    check_reset_values("reset");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset_values("post_reset");

    // Vector table
    for (int i = 0; i < 11; i++) run_vec(vecs[i]);
    check("stray_clean", stray_rsp, 0);

    // Back-to-back requests with valid held high
    v1 = mk(0, 0, 16'h0100, 32'h0, 0, 0, 32'h11111111);
    v2 = mk(0, 0, 16'h0200, 32'h0, 1, 0, 32'h22222222);
    exp_q.push_back({1'b0, v1.rdata});
    host_drive(v1);
    wait_ready(acc);
    @(negedge clk);
    req_addr = v2.addr;
    csb_serve(v1, 1'b1);
    check("b2b_first_rsp", rsp_valid, 1);
    check("b2b_ready_in_resp", req_ready, 0);
    exp_q.push_back({1'b0, v2.rdata});
    @(negedge clk);
    check("b2b_rsp_single", rsp_valid, 0);
    check("b2b_ready_after_resp", req_ready, 1);
    @(negedge clk);
    req_valid = 1'b0;
    csb_serve(v2, 1'b1);
    check("b2b_second_rsp", rsp_valid, 1);
    @(negedge clk);

    // Posted write followed by a late completion
    run_vec(mk(1, 0, 16'h0044, 32'h0BADC0DE, 0, 0, 32'h0));
    check("posted_no_stray", stray_rsp, 0);
    csb_wr_complete = 1'b1;
    @(negedge clk);
    csb_wr_complete = 1'b0;
    check("posted_late_complete_stray", stray_rsp, 1);
    @(negedge clk);
    check("stray_sticky", stray_rsp, 1);

    // Reset while waiting for read data
    v1 = mk(0, 0, 16'h0030, 32'h0, 0, 0, 32'h33333333);
    exp_q.push_back({1'b0, v1.rdata});
    host_drive(v1);
    wait_ready(acc);
    @(negedge clk);
    req_valid = 1'b0;
    csb_serve(v1, 1'b0);
    check("mid_state_wait_read", dbg_state, S_WAIT_READ);
    rst = 1'b1;
    #1;
    check_reset_values("mid_reset");
    void'(exp_q.pop_back());
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_vec(mk(0, 0, 16'h0031, 32'h0, 0, 0, 32'h44444444));

`ifdef CSB_MASTER_TIMEOUT_EN
    // Read that is never answered
    v1 = mk(0, 0, 16'h0050, 32'h0, 0, 0, 32'h0);
    exp_q.push_back({1'b1, 32'h0});
    host_drive(v1);
    wait_ready(acc);
    @(negedge clk);
    req_valid = 1'b0;
    csb_serve(v1, 1'b0);
    w = cyc;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("timeout_latency", cyc - w, TO_CYCLES);
    check("timeout_error", rsp_error, 1);
    @(negedge clk);
    check("timeout_no_stray_yet", stray_rsp, 0);
    csb_r_valid = 1'b1;
    csb_r_data  = 32'h55555555;
    @(negedge clk);
    csb_r_valid = 1'b0;
    check("timeout_late_read_stray", stray_rsp, 1);
`endif

    repeat (3) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
